// File: rtl/neuron_lut_pkg.sv
// neuron_lut_pkg
// Shared definitions for the runtime-loadable truth-table neuron:
//   - lut_state_t : loader state (EMPTY / LOAD / READY)
//   - DEF_*       : default geometry (6 address bits, 2-bit entries, 16-bit config words)
//   - calc_epw / calc_entries : derived table geometry
package neuron_lut_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } lut_state_t;

  localparam int DEF_IN_BITS  = 6;
  localparam int DEF_OUT_BITS = 2;
  localparam int DEF_WORD_W   = 16;

  // Table entries carried by one config word.
  function automatic int calc_epw(input int word_w, input int out_bits);
    return word_w / out_bits;
  endfunction

  // Table depth for a given lookup address width.
  function automatic int calc_entries(input int in_bits);
    return 1 << in_bits;
  endfunction

endpackage

// File: rtl/neuron_lut_ram.sv
// neuron_lut_ram
// Distributed-RAM truth table. One wide write port stores EPW consecutive
// entries starting at wr_base; a registered lookup port serves the neuron.
// Optional macro NEURON_LUT_READBACK_EN adds a second registered read port.
// Ports:
//   clk, rst        clock, async active-high reset (read registers only)
//   we, wr_base,    write EPW entries at wr_base .. wr_base+EPW-1
//   wr_data
//   rd_en, rd_addr  lookup request; rd_data updates one cycle later, else holds
//   rd_data
//   rb_en, rb_addr, readback request/result (NEURON_LUT_READBACK_EN only)
//   rb_data, rb_ack
import neuron_lut_pkg::*;

module neuron_lut_ram #(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int EPW      = calc_epw(DEF_WORD_W, DEF_OUT_BITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IN_BITS-1:0]      wr_base,
  input  logic [EPW*OUT_BITS-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [IN_BITS-1:0]      rd_addr,
  output logic [OUT_BITS-1:0]     rd_data
`ifdef NEURON_LUT_READBACK_EN
  ,
  input  logic                    rb_en,
  input  logic [IN_BITS-1:0]      rb_addr,
  output logic [OUT_BITS-1:0]     rb_data,
  output logic                    rb_ack
`endif
);

  localparam int ENTRIES = calc_entries(IN_BITS);

  logic [OUT_BITS-1:0] mem [ENTRIES];

  // Contents are deliberately not reset; the loader's loaded flag keeps
  // stale or partial images from ever being served.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < EPW; k++) begin
        mem[wr_base + IN_BITS'(k)] <= wr_data[k*OUT_BITS +: OUT_BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

`ifdef NEURON_LUT_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_data <= '0;
      rb_ack  <= 1'b0;
    end else begin
      rb_ack <= rb_en;
      if (rb_en) begin
        rb_data <= mem[rb_addr];
      end
    end
  end
`endif

endmodule

// File: rtl/neuron_lut_loader.sv
// neuron_lut_loader
// Runtime-programmable truth-table neuron: accepts a packed table image from
// the config path, fills the table, then serves registered lookups.
// Optional macro NEURON_LUT_READBACK_EN adds a table readback port.
// Ports:
//   clk, rst                      clock, async active-high reset
//   cfg_start                     pulse: begin/restart a table load
//   cfg_valid, cfg_ready,         config word handshake, entry k in
//   cfg_data                        cfg_data[k*OUT_BITS +: OUT_BITS]
//   cfg_done                      pulse the cycle after the final word
//   loaded                        table holds a complete image
//   in_valid, in_ready, in_addr   lookup request (in_ready == loaded)
//   out_valid, out_data           lookup result, one cycle latency
//   rb_valid, rb_addr, rb_data,   readback (NEURON_LUT_READBACK_EN only)
//   rb_ack
//
// state | meaning
// EMPTY | no valid image, waiting for cfg_start
// LOAD  | accepting config words, counting toward a full image
// READY | full image present, lookups accepted
import neuron_lut_pkg::*;

module neuron_lut_loader #(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int WORD_W   = DEF_WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  output logic                cfg_done,
  output logic                loaded,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_addr,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
`ifdef NEURON_LUT_READBACK_EN
  ,
  input  logic                rb_valid,
  input  logic [IN_BITS-1:0]  rb_addr,
  output logic [OUT_BITS-1:0] rb_data,
  output logic                rb_ack
`endif
);

  localparam int EPW     = calc_epw(WORD_W, OUT_BITS);
  localparam int ENTRIES = calc_entries(IN_BITS);
  localparam int NWORDS  = ENTRIES / EPW;
  localparam int CW      = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  lut_state_t          state, state_nxt;
  logic [CW-1:0]       ctr;
  logic                accept;
  logic                last_word;
  logic                rd_en;
  logic [IN_BITS-1:0]  wr_base;

  assign accept    = cfg_valid && cfg_ready;
  assign last_word = (ctr == CW'(NWORDS - 1));
  assign rd_en     = in_valid && in_ready;
  assign wr_base   = IN_BITS'(int'(ctr) * EPW);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; cfg_start wins over everything, including a final word.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (cfg_start) state_nxt = LOAD;
      LOAD:    if (!cfg_start && accept && last_word) state_nxt = READY;
      READY:   if (cfg_start) state_nxt = LOAD;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output logic; a word alongside cfg_start is refused so the restart
  // always begins cleanly at address 0.
  always_comb begin
    cfg_ready = 1'b0;
    loaded    = 1'b0;
    case (state)
      LOAD:    cfg_ready = !cfg_start;
      READY:   loaded    = 1'b1;
      default: ;
    endcase
    in_ready = loaded;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr       <= '0;
      cfg_done  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (cfg_start) begin
        ctr <= '0;
      end else if (accept) begin
        ctr <= ctr + CW'(1);
      end
      cfg_done  <= accept && last_word;
      out_valid <= rd_en;
    end
  end

  neuron_lut_ram #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .EPW      (EPW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (accept),
    .wr_base (wr_base),
    .wr_data (cfg_data),
    .rd_en   (rd_en),
    .rd_addr (in_addr),
    .rd_data (out_data)
`ifdef NEURON_LUT_READBACK_EN
    ,
    .rb_en   (rb_valid),
    .rb_addr (rb_addr),
    .rb_data (rb_data),
    .rb_ack  (rb_ack)
`endif
  );

endmodule

// File: tb/tb_neuron_lut_loader.sv
// tb_neuron_lut_loader
// Directed bench for neuron_lut_loader with a transaction-level table model.
// Inputs change 2 time units after the rising edge; outputs are compared on
// the falling edge. Readback checks are added when NEURON_LUT_READBACK_EN is set.
module tb_neuron_lut_loader;

  localparam int IN_BITS  = 6;
  localparam int OUT_BITS = 2;
  localparam int WORD_W   = 16;
  localparam int EPW      = 8;
  localparam int NWORDS   = 8;

  logic                clk       = 1'b0;
  logic                rst       = 1'b1;
  logic                cfg_start = 1'b0;
  logic                cfg_valid = 1'b0;
  logic [WORD_W-1:0]   cfg_data  = '0;
  logic                in_valid  = 1'b0;
  logic [IN_BITS-1:0]  in_addr   = '0;
  logic                cfg_ready, cfg_done, loaded, in_ready, out_valid;
  logic [OUT_BITS-1:0] out_data;
`ifdef NEURON_LUT_READBACK_EN
  logic                rb_valid  = 1'b0;
  logic [IN_BITS-1:0]  rb_addr   = '0;
  logic [OUT_BITS-1:0] rb_data;
  logic                rb_ack;
`endif

  neuron_lut_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_done  (cfg_done),
    .loaded    (loaded),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef NEURON_LUT_READBACK_EN
    ,
    .rb_valid  (rb_valid),
    .rb_addr   (rb_addr),
    .rb_data   (rb_data),
    .rb_ack    (rb_ack)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int ov_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an image is complete after NWORDS accepted words since the last
  // cfg_start; lookups see the table as it was before the accepting edge.
  logic [OUT_BITS-1:0] m_table [64];
  bit                  m_loading = 1'b0;
  bit                  m_loaded  = 1'b0;
  int                  m_words   = 0;
  logic                exp_done  = 1'b0;
  logic                exp_valid = 1'b0;
  logic [OUT_BITS-1:0] exp_data  = '0;

  initial for (int i = 0; i < 64; i++) m_table[i] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading = 1'b0;
      m_loaded  = 1'b0;
      m_words   = 0;
      exp_done  = 1'b0;
      exp_valid = 1'b0;
      exp_data  = '0;
    end else begin
      exp_valid = in_valid && m_loaded;
      if (exp_valid) exp_data = m_table[in_addr];
      exp_done = 1'b0;
      if (cfg_start) begin
        m_loading = 1'b1;
        m_loaded  = 1'b0;
        m_words   = 0;
      end else if (m_loading && cfg_valid) begin
        for (int k = 0; k < EPW; k++)
          m_table[m_words*EPW + k] = cfg_data[k*OUT_BITS +: OUT_BITS];
        m_words++;
        if (m_words == NWORDS) begin
          m_loading = 1'b0;
          m_loaded  = 1'b1;
          exp_done  = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cfg_ready", 32'(cfg_ready), 32'(m_loading && !cfg_start));
    chk("loaded",    32'(loaded),    32'(m_loaded));
    chk("in_ready",  32'(in_ready),  32'(m_loaded));
    chk("cfg_done",  32'(cfg_done),  32'(exp_done));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out_data",  32'(out_data),  32'(exp_data));
    if (cfg_done)  done_cnt++;
    if (out_valid) ov_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic start_load;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_words(input logic [127:0] img, input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = img[i*16 +: 16];
      tick();
      if (toggle && i < n - 1) begin
        cfg_valid = 1'b0;
        tick();
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic sweep_lookups;
    ov_cnt = 0;
    for (int a = 0; a < 64; a++) begin
      in_valid = 1'b1;
      in_addr  = IN_BITS'(a);
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic lookup(input int a);
    in_valid = 1'b1;
    in_addr  = IN_BITS'(a);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int d0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state and refused lookups while EMPTY
    chk("rst out_data", 32'(out_data), 32'h0);
    chk("rst cfg_done", 32'(cfg_done), 32'h0);
    in_valid = 1'b1;
    in_addr  = 6'd5;
    repeat (3) tick();
    chk("empty in_ready", 32'(in_ready), 32'h0);
    chk("empty out_valid", 32'(out_valid), 32'h0);
    in_valid = 1'b0;

    // Load a = a[1:0] image
    d0 = done_cnt;
    start_load();
    send_words({8{16'hE4E4}}, 8, 1'b0);
    chk("load1 cfg_done", 32'(cfg_done), 32'h1);
    chk("load1 loaded", 32'(loaded), 32'h1);
    tick();
    chk("load1 done pulses", 32'(done_cnt - d0), 32'h1);
    lookup(37);
    chk("lookup37 valid", 32'(out_valid), 32'h1);
    chk("lookup37 data", 32'(out_data), 32'h1);
    tick();

    // Back-to-back lookups over the whole table
    sweep_lookups();
    chk("sweep count", 32'(ov_cnt), 32'd64);

    // Toggling cfg_valid with a mixed image
    d0 = done_cnt;
    start_load();
    send_words({16'hC3C3, 16'h3C3C, 16'hE4E4, 16'h1B1B,
                16'hFFFF, 16'hAAAA, 16'h5555, 16'h0000}, 8, 1'b1);
    chk("load2 cfg_done", 32'(cfg_done), 32'h1);
    tick();
    chk("load2 done pulses", 32'(done_cnt - d0), 32'h1);
    lookup(8);
    chk("lookup8 data", 32'(out_data), 32'h1);
    lookup(16);
    chk("lookup16 data", 32'(out_data), 32'h2);
    lookup(63);
    chk("lookup63 data", 32'(out_data), 32'h3);
    tick();
    sweep_lookups();
    chk("sweep2 count", 32'(ov_cnt), 32'd64);

    // cfg_start from READY with a lookup in flight, then restart mid-load
    cfg_start = 1'b1;
    in_valid  = 1'b1;
    in_addr   = 6'd8;
    tick();
    cfg_start = 1'b0;
    chk("inflight valid", 32'(out_valid), 32'h1);
    chk("inflight data", 32'(out_data), 32'h1);
    chk("restart loaded drop", 32'(loaded), 32'h0);
    in_addr = 6'd3;
    send_words({8{16'h0000}}, 4, 1'b0);
    chk("during load refused", 32'(out_valid), 32'h0);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 16'h0000;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    d0 = done_cnt;
    send_words({8{16'hFFFF}}, 8, 1'b0);
    chk("restart loaded", 32'(loaded), 32'h1);
    tick();
    chk("restart done pulses", 32'(done_cnt - d0), 32'h1);
    lookup(0);
    chk("ffff lookup0", 32'(out_data), 32'h3);
    tick();
    sweep_lookups();

    // Reset in the middle of a load
    start_load();
    send_words({8{16'hE4E4}}, 5, 1'b0);
`ifdef NEURON_LUT_READBACK_EN
    rb_valid = 1'b1;
    rb_addr  = 6'd37;
    tick();
    rb_valid = 1'b0;
    chk("rb ack", 32'(rb_ack), 32'h1);
    chk("rb data", 32'(rb_data), 32'h1);
    tick();
    chk("rb ack drop", 32'(rb_ack), 32'h0);
`endif
    chk("midload cfg_ready", 32'(cfg_ready), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst cfg_ready", 32'(cfg_ready), 32'h0);
    chk("rst loaded", 32'(loaded), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    d0 = done_cnt;
    start_load();
    send_words({16'h1B1B, 16'h1B1B, 16'hE4E4, 16'hE4E4,
                16'hE4E4, 16'hE4E4, 16'hE4E4, 16'hE4E4}, 8, 1'b0);
    chk("reload loaded", 32'(loaded), 32'h1);
    tick();
    chk("reload done pulses", 32'(done_cnt - d0), 32'h1);
    lookup(42);
    chk("reload lookup42", 32'(out_data), 32'h2);
    lookup(57);
    chk("reload lookup57", 32'(out_data), 32'h2);
    tick();
    sweep_lookups();
    chk("sweep3 count", 32'(ov_cnt), 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
